addsub_seq_ctrl: RTL
====================

# addsub_seq_ctrl

Sequential issue/capture stage wrapped around the 32-bit ripple-carry add/sub datapath (`addsub32`). It accepts an operand pair over a valid/ready handshake, holds A, B and SUB stable on the adder inputs for a fixed number of settle cycles to cover worst-case carry ripple, then registers the sum, carry, overflow and derived N/Z flags. It presents the captured result downstream over a second valid/ready handshake.

## Interface
Parameters:
- SETTLE, 8, clock cycles the operands are held before result capture; legal range 1..15. Default covers the 32-bit unit-delay ripple (~66 ns) at a 10 ns clock.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand request
- in_ready  out  1  stage can accept an operand
- in_a  in  32  operand A
- in_b  in  32  operand B
- in_sub  in  1  1 = A-B, 0 = A+B
- add_a  out  32  registered, drives `addsub32` A
- add_b  out  32  registered, drives `addsub32` B
- add_sub  out  1  registered, drives `addsub32` SUB
- add_ans  in  32  from `addsub32` ans
- add_cout  in  1  from `addsub32` cout
- add_v  in  1  from `addsub32` V
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_ans  out  32  captured result
- out_c, out_v, out_n, out_z  out  1 each  captured carry, overflow, negative, zero
- busy  out  1  state != IDLE
- sticky_v  out  1  sticky overflow (see Configuration)
- clr_sticky  in  1  clears sticky_v

## Operation
- FSM states: IDLE, SETTLE, HOLD. Counter `cnt` is 4 bits.
- IDLE: in_ready=1. On in_valid: latch in_a/in_b/in_sub into add_a/add_b/add_sub, load cnt=SETTLE-1, go to SETTLE.
- SETTLE: in_ready=0; add_* held constant; decrement cnt. When cnt==0, capture add_ans→out_ans, add_cout→out_c, add_v→out_v, add_ans[31]→out_n, (add_ans==0)→out_z. Set out_valid=1 and go to HOLD.
- HOLD: out_valid=1; all out_* stable. On out_ready, clear out_valid and go to IDLE.
- out_c is the raw adder cout for both add and sub; there is no borrow inversion (sub with A≥B unsigned gives out_c=1).
- add_* keep their last values in IDLE and HOLD and change only on an accept.
- in_valid is ignored outside IDLE, and in_* are ignored outside the accept edge.

## Timing
- Reset (rst=1 at an edge): state=IDLE, cnt=0, add_a/add_b=0, add_sub=0, out_valid=0, all out_* flags and out_ans=0, busy=0, sticky_v=0. in_ready is forced to 0 while rst=1 and becomes 1 in the first cycle after rst deasserts.
- Reset asserted mid-SETTLE or mid-HOLD aborts the operation immediately. No result is emitted.
- Latency: accept at edge k → out_valid high after edge k+SETTLE.
- Minimum issue period is SETTLE+2 cycles: capture, output handshake, then one IDLE cycle.
- out_valid held with out_ready=0: out_* remain stable indefinitely.
- out_valid, in_ready and busy are decoded from registered state only. There are no combinational paths from inputs to these outputs, apart from the rst gating on in_ready.

## Configuration
- `ADDSUB_STICKY_EN` defined:
  - sticky_v sets on any capture with add_v=1 and stays set until clr_sticky=1 or rst.
  - If clr_sticky and a V=1 capture occur at the same edge, the set wins.
- Not defined: sticky_v is tied to 0 and clr_sticky is ignored. The ports remain present.

## Test plan
- Clock 10 ns, SETTLE=8, real unit-delay `addsub32`. Issue A=7FFFFFFF, B=00000001, SUB=0 → out_valid exactly 8 cycles after accept; out_ans=80000000, C=0, V=1, N=1, Z=0.
- A=336FB7E5, B=336FB7E5, SUB=1 → out_ans=00000000, C=1, V=0, N=0, Z=1.
- A=80000000, B=00000001, SUB=1 with out_ready=0 for 20 cycles → out_ans=7FFFFFFF, V=1 held stable; in_ready stays 0; a second in_valid is not accepted until 1 cycle after the out handshake.
- Back-to-back issue with in_valid and out_ready held at 1 → accepts every 10 cycles. Results in order: 00000021+00000022 → 00000043, then FFFFFFFF−13B72214 → EC48DDEB with C=1.
- Assert rst at SETTLE cycle 3 → out_valid never rises, all outputs are 0, and in_ready=1 one cycle after rst drops.
- With `ADDSUB_STICKY_EN`: overflow op 784EBA56+7B5140F2 → sticky_v=1. It stays 1 across a following non-overflow op and clears after a clr_sticky pulse. Without the macro, sticky_v stays 0 throughout.

Source files
------------

// File: rtl/addsub_seq_ctrl_if.sv
// Operand-request and result-delivery handshakes of the add/sub issue stage.
// slave = the stage itself, master = the upstream/downstream side driving it.
interface addsub_seq_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        in_sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_ans;
   logic        out_c;
   logic        out_v;
   logic        out_n;
   logic        out_z;

   modport slave (
      input  in_valid, in_a, in_b, in_sub, out_ready,
      output in_ready, out_valid, out_ans, out_c, out_v, out_n, out_z
   );

   modport master (
      output in_valid, in_a, in_b, in_sub, out_ready,
      input  in_ready, out_valid, out_ans, out_c, out_v, out_n, out_z
   );
endinterface

// File: rtl/addsub_seq_ctrl.sv
// Issue/capture stage around the addsub32 ripple adder: hold operands SETTLE cycles, then capture.
// Optional sticky overflow flag enabled by defining ADDSUB_STICKY_EN.
//
// state    | meaning
// S_IDLE   | ready for an operand pair, adder inputs keep last values
// S_SETTLE | operands held on the adder, cnt counting down to capture
// S_HOLD   | captured result presented, waiting for out_ready
module addsub_seq_ctrl #(
   parameter int unsigned SETTLE = 8
) (
   input  logic               clk,
   input  logic               rst,
   addsub_seq_ctrl_if.slave   bus,
   output logic [31:0]        add_a,
   output logic [31:0]        add_b,
   output logic               add_sub,
   input  logic [31:0]        add_ans,
   input  logic               add_cout,
   input  logic               add_v,
   output logic               busy,
   output logic               sticky_v,
   input  logic               clr_sticky
);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        accept, capture;
   logic [31:0] ans_q;
   logic        c_q, v_q, n_q, z_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         add_a   <= 32'd0;
         add_b   <= 32'd0;
         add_sub <= 1'b0;
         ans_q   <= 32'd0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            add_a   <= bus.in_a;
            add_b   <= bus.in_b;
            add_sub <= bus.in_sub;
         end
         if (capture) begin
            ans_q <= add_ans;
            c_q   <= add_cout;
            v_q   <= add_v;
            n_q   <= add_ans[31];
            z_q   <= (add_ans == 32'd0);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      capture   = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.in_valid) begin
               accept    = 1'b1;
               cnt_nxt   = CNT_LOAD;
               state_nxt = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt == 4'd0) begin
               capture   = 1'b1;
               state_nxt = S_HOLD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_HOLD: begin
            if (bus.out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs come from registered state; only rst gates in_ready.
   assign bus.in_ready  = (state == S_IDLE) && !rst;
   assign bus.out_valid = (state == S_HOLD);
   assign busy          = (state != S_IDLE);
   assign bus.out_ans   = ans_q;
   assign bus.out_c     = c_q;
   assign bus.out_v     = v_q;
   assign bus.out_n     = n_q;
   assign bus.out_z     = z_q;

`ifdef ADDSUB_STICKY_EN
   logic sticky_q;

   // A set on a capture edge takes priority over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst)                     sticky_q <= 1'b0;
      else if (capture && add_v)   sticky_q <= 1'b1;
      else if (clr_sticky)         sticky_q <= 1'b0;
   end

   assign sticky_v = sticky_q;
`else
   logic unused_clr_sticky;

   assign unused_clr_sticky = clr_sticky;
   assign sticky_v          = 1'b0;
`endif

endmodule
